cla_add_sequencer: RTL
======================

Name: cla_add_sequencer

Overview:
- Operand-issue and result-capture stage that sits directly upstream of the registered 32-bit carry-lookahead adder (ports A, B, Sum, Cout, clock, reset).
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Presents one pair at a time to the adder, holds it stable for the adder latency, captures Sum/Cout, and returns the result over a second valid/ready handshake.
- Between operations, adder inputs are driven to zero so every adder transition is isolated.

Parameters:
WIDTH, 32, operand/sum width
DEPTH, 4, input FIFO depth (power of 2, >=2)
ADD_LAT, 1, adder latency: rising edges from A/B change to registered Sum/Cout update (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO not full (registered)
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
add_a  out  WIDTH  to adder A (registered)
add_b  out  WIDTH  to adder B (registered)
add_sum  in  WIDTH  from adder Sum
add_cout  in  1  from adder Cout
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  captured sum
out_cout  out  1  captured carry-out
busy  out  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; FSM to IDLE.
  - add_a, add_b, out_sum, out_cout, out_valid, wait counter all 0.
  - in_ready=1, busy=0.
  - Applies mid-operation with no completion; the in-flight op is discarded.
- Input push: on a clock edge with in_valid && in_ready.
  - in_ready = !full, derived from registered pointers/count; no combinational path from out_ready or pop.
  - Full FIFO with a pop on the same edge: push is still refused that cycle; in_ready rises the next cycle.
- FIFO: DEPTH entries, wrap-around pointers, occupancy count 0..DEPTH. Push and pop on the same edge keeps the count unchanged.
- FSM states IDLE, WAIT, HOLD:
  - IDLE:
    - FIFO non-empty: pop head; load add_a/add_b with head on that edge (issue edge T0); load counter=ADD_LAT; go WAIT.
    - FIFO empty: add_a/add_b held at 0.
  - WAIT:
    - add_a/add_b held stable.
    - Counter decrements each edge.
    - On the edge where counter==0 (edge T0+ADD_LAT+1): out_sum<=add_sum, out_cout<=add_cout, out_valid<=1, add_a/add_b<=0; go HOLD.
  - HOLD:
    - out_sum/out_cout/out_valid held.
    - On an edge with out_valid && out_ready: out_valid<=0; go IDLE.
    - No issue in HOLD, so add inputs stay 0.
- Ordering and throughput:
  - Results emerge strictly in push order.
  - Minimum spacing between issue edges is ADD_LAT+3 cycles when out_ready is tied high: IDLE, WAIT x(ADD_LAT+1), HOLD.
- Arithmetic: no width change. out_sum is the WIDTH-bit sum; out_cout is bit WIDTH of A+B exactly as the adder reports. This stage does no modification or overflow detection.
- Backpressure: out_ready low holds HOLD indefinitely. The FIFO keeps accepting until full.
- in_valid while in_ready=0 is ignored; data is not latched.
- busy=0 only when the FSM is in IDLE and the FIFO is empty.

Test Plan:
- Reset: assert reset=0 mid-WAIT with 3 entries queued -> all outputs 0 immediately (asynchronous), in_ready=1, busy=0; after release no result appears.
- Single op, ADD_LAT=1, out_ready=1: push A=00FF_00FF, B=FF00_FF01 -> add_a/add_b change 1 edge after pop; out_valid rises at issue+2 edges with out_sum=0000_0000, out_cout=1; add_a/add_b return to 0 on that same edge.
- Ordered burst: push 8080_8080+8080_8080, 0000_00FF+FFFF_FF80, 1111_1111+2222_2222 back-to-back -> results in order: 0101_0100/1, 0000_007F/1, 3333_3333/0; adder inputs are 0 for at least one cycle between ops.
- Full FIFO: hold out_ready=0, push 5 pairs -> first issued, next 4 fill FIFO (DEPTH=4), in_ready=0, a 6th in_valid is ignored; release out_ready -> exactly 5 results in order.
- Backpressure hold: out_ready=0 for 10 cycles in HOLD -> out_sum/out_cout/out_valid stable; one out_ready pulse -> out_valid drops next edge.
- ADD_LAT=3 build: single op 1111_1111+2222_2222 -> capture at issue+4 edges, out_sum=3333_3333, out_cout=0.

Source files
------------

// File: rtl/cla_add_sequencer.sv
// Operand-issue / result-capture stage for a registered carry-lookahead adder.
// Queues operand pairs, isolates each adder operation, returns Sum/Cout in order.
module cla_add_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic [CW-1:0]    wait_cnt;
  logic             push;
  logic             pop;

  // in_ready depends only on the registered count, never on pop
  assign in_ready = (count != DEPTH[AW:0]);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign busy     = (state != IDLE) || (count != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      add_a     <= '0;
      add_b     <= '0;
      wait_cnt  <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            add_a    <= mem_a[rd_ptr];
            add_b    <= mem_b[rd_ptr];
            wait_cnt <= ADD_LAT[CW-1:0];
            state    <= WAIT;
          end else begin
            add_a <= '0;
            add_b <= '0;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            out_sum   <= add_sum;
            out_cout  <= add_cout;
            out_valid <= 1'b1;
            add_a     <= '0;
            add_b     <= '0;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
